// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide sequencer beside the EX-stage ALU.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves RUN once the multiplier is exhausted.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             DX_muldiv,
    input  logic [1:0]       DX_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_p;
    logic [2*WIDTH-1:0] r_m;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_busy;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_start;
    logic               w_mul;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_amag;
    logic [WIDTH-1:0]   w_bmag;
    logic [2*WIDTH-1:0] w_padd;
    logic [WIDTH:0]     w_rs;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_qmag;
    logic [WIDTH-1:0]   w_rmag;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
`ifdef MULDIV_EARLY_OUT_EN
    logic               w_mul_last;
    assign w_mul_last = ((r_b >> 1) == '0);
`endif

    assign w_start = (r_state == S_IDLE) && DX_muldiv && !flush;
    assign w_mul   = ~r_op[1];
    assign w_sgn   = ~r_op[0];
    assign w_amag  = (w_sgn && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_bmag  = (w_sgn && r_b[WIDTH-1]) ? -r_b : r_b;

    // Multiply: add the left-shifting multiplicand per set multiplier bit.
    assign w_padd = r_p + (r_b[0] ? r_m : '0);

    // Divide: r_p holds {remainder, dividend->quotient}; restoring step.
    assign w_rs   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    assign w_diff = w_rs - {1'b0, r_m[WIDTH-1:0]};
    assign w_qmag = r_p[WIDTH-1:0];
    assign w_rmag = r_p[2*WIDTH-1:WIDTH];

    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        if (w_mul) begin
            {w_res_hi, w_res_lo} = r_neg_q ? -r_p : r_p;
        end else if (r_dz) begin
            w_res_hi = r_a;
            w_res_lo = '1;
        end else begin
            w_res_hi = r_neg_r ? -w_rmag : w_rmag;
            w_res_lo = r_neg_q ? -w_qmag : w_qmag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_next = S_PREP;
            S_PREP: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
                    if (w_mul && w_bmag == '0) w_next = S_FIX;
`endif
                end
            end
            S_RUN: begin
                // A zero divisor still walks RUN so divide latency stays fixed.
                if (flush) begin
                    w_next = S_IDLE;
                end else begin
                    if (r_cnt == '0) w_next = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
                    if (w_mul && w_mul_last) w_next = S_FIX;
`endif
                end
            end
            S_FIX:   w_next = flush ? S_IDLE : S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_p        <= '0;
            r_m        <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_busy     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op       <= DX_op;
                        r_a        <= A;
                        r_b        <= B;
                        r_div_zero <= 1'b0;
                    end
                end
                S_PREP: begin
                    r_cnt   <= CW'(WIDTH - 1);
                    r_neg_q <= w_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_r <= w_sgn & r_a[WIDTH-1];
                    r_dz    <= ~w_mul & (r_b == '0);
                    if (w_mul) begin
                        r_p <= '0;
                        r_m <= {{WIDTH{1'b0}}, w_amag};
                        r_b <= w_bmag;
                    end else begin
                        r_p <= {{WIDTH{1'b0}}, w_amag};
                        r_m <= {{WIDTH{1'b0}}, w_bmag};
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (w_mul) begin
                        r_p <= w_padd;
                        r_m <= r_m << 1;
                        r_b <= r_b >> 1;
                    end else if (!w_diff[WIDTH]) begin
                        r_p <= {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
                    end else begin
                        r_p <= {w_rs[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_hi <= w_res_hi;
                        r_lo <= w_res_lo;
                        if (r_dz) r_div_zero <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall    = (r_state == S_PREP) || (r_state == S_RUN) ||
                      (r_state == S_FIX) || w_start;
    assign busy     = r_busy;
    assign done     = (r_state == S_DONE);
    assign div_zero = r_div_zero;
    assign HI       = r_hi;
    assign LO       = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors, decoupled monitor.
// Latency expectations follow MULDIV_EARLY_OUT_EN when defined.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         DX_muldiv = 1'b0;
    logic [1:0]   DX_op = 2'b00;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         flush = 1'b0;
    logic         stall;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .DX_muldiv(DX_muldiv), .DX_op(DX_op),
        .A(A), .B(B), .flush(flush), .stall(stall), .busy(busy),
        .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           at;
    } exp_t;

    exp_t sbq[$];
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, act, req);
        end
    endtask

    function automatic int lat_of(input logic [1:0] op, input logic [W-1:0] b);
        int l;
        logic eo;
        logic [W-1:0] m;
`ifdef MULDIV_EARLY_OUT_EN
        eo = 1'b1;
`else
        eo = 1'b0;
`endif
        l = W + 3;
        if (eo && !op[1]) begin
            m = (!op[0] && b[W-1]) ? -b : b;
            l = 3;
            for (int i = 0; i < W; i++) if (m[i]) l = 4 + i;
        end
        return l;
    endfunction

    // Time convention: tasks start and end 1 time unit after a rising edge.
    task automatic run(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] hi,
                       input logic [W-1:0] lo, input logic dz);
        int  lat;
        int  stalls;
        bit  got;
        lat = lat_of(op, b);
        DX_op = op;
        A = a;
        B = b;
        DX_muldiv = 1'b1;
        #1;
        chk("stall_start", stall, 1);
        sbq.push_back('{hi, lo, dz, cyc + lat});
        last_hi = hi;
        last_lo = lo;
        stalls = stall ? 1 : 0;
        @(posedge clk);
        #1;
        DX_muldiv = 1'b0;
        DX_op = ~op;
        A = ~a;
        B = ~b;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (stall) stalls++;
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL done_timeout op=%b a=%h b=%h", op, a, b);
        end
        chk("stall_cycles", stalls, lat);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sbq.pop_front();
                chk("hi", HI, e.hi);
                chk("lo", LO, e.lo);
                chk("div_zero", div_zero, e.dz);
                chk("latency_cycle", cyc, e.at);
                chk("stall_in_done", stall, 0);
            end
        end
    end

    initial begin
        int flw;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        chk("rst_dz", div_zero, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run(2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 0);
        run(2'b00, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
        run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0);
        run(2'b01, 32'h00001234, 32'h00000000, 32'h00000000, 32'h00000000, 0);
        run(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run(2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 0);
        run(2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1);
        run(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
        run(2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);

        // Flush while multu 3*4 is in RUN.
`ifdef MULDIV_EARLY_OUT_EN
        flw = 2;
`else
        flw = 11;
`endif
        DX_op = 2'b01;
        A = 32'd3;
        B = 32'd4;
        DX_muldiv = 1'b1;
        @(posedge clk);
        #1;
        DX_muldiv = 1'b0;
        repeat (flw) @(posedge clk);
        chk("busy_before_flush", busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_stall", stall, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_hi_kept", HI, last_hi);
        chk("flush_lo_kept", LO, last_lo);

        // Start and flush in the same IDLE cycle.
        DX_muldiv = 1'b1;
        flush = 1'b1;
        #1;
        chk("sf_stall", stall, 0);
        @(posedge clk);
        #1;
        chk("sf_busy", busy, 0);
        DX_muldiv = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset during RUN.
        DX_op = 2'b11;
        A = 32'h0000FFFF;
        B = 32'd3;
        DX_muldiv = 1'b1;
        @(posedge clk);
        #1;
        DX_muldiv = 1'b0;
        repeat (21) @(posedge clk);
        #3;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("arst_hi", HI, 0);
        chk("arst_lo", LO, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_stall", stall, 0);
        chk("arst_dz", div_zero, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        run(2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 0);
        run(2'b01, 32'd5, 32'd1, 32'd0, 32'd5, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
